// File: rtl/fpu_adder_pkg.sv
//------------------------------------------------------------------------------
// fpu_adder_pkg : shared constants, special-case codes and unpack helpers
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fpu_adder_pkg;

   localparam int EXP_W     = 8;
   localparam int FRAC_W    = 23;
   localparam int MANT_W    = 27;
   localparam int SHIFT_SAT = 27;
   localparam int SHAMT_W   = 5;

   typedef enum logic [1:0] {
      SPC_NORMAL = 2'b00,
      SPC_INF    = 2'b01,
      SPC_NAN    = 2'b10
   } special_e;

   typedef struct packed {
      logic [EXP_W-1:0]   exp_big;
      logic [MANT_W-1:0]  mant_big;
      logic [MANT_W-1:0]  mant_small;
      logic [SHAMT_W-1:0] shamt;
      logic               sign_big;
      logic               eff_sub;
      special_e           special;
   } s1_t;

   // Denormals and zero behave as exponent 1 with a cleared hidden bit.
   function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
      return (e == '0) ? EXP_W'(1) : e;
   endfunction

   function automatic logic [MANT_W-1:0] unpack_mant(input logic [EXP_W-1:0]  e,
                                                     input logic [FRAC_W-1:0] f);
      return {(e != '0), f, 3'b000};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sticky_rshift.sv
//------------------------------------------------------------------------------
// sticky_rshift : combinational right shift, shifted-out bits ORed into bit 0
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sticky_rshift
   import fpu_adder_pkg::*;
(
   input  logic [MANT_W-1:0]  din,
   input  logic [SHAMT_W-1:0] amt,
   output logic [MANT_W-1:0]  dout
);

   logic [MANT_W-1:0] shifted;
   logic [MANT_W-1:0] lost_mask;
   logic              sticky;

   always_comb begin
      shifted   = din >> amt;
      lost_mask = ~({MANT_W{1'b1}} << amt);
      sticky    = |(din & lost_mask);
      dout      = {shifted[MANT_W-1:1], shifted[0] | sticky};
   end

endmodule

`default_nettype wire

// File: rtl/align_stage.sv
//------------------------------------------------------------------------------
// align_stage : two-stage FP32 adder alignment (compare/swap, then sticky shift)
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module align_stage
   import fpu_adder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       a,
   input  logic [31:0]       b,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EXP_W-1:0]  mux_out,
   output logic [MANT_W-1:0] mant_big,
   output logic [MANT_W-1:0] mant_small,
   output logic              sign_big,
   output logic              eff_sub,
   output logic [1:0]        special
);

   logic               s1_valid_q, s1_valid_d;
   s1_t                s1_q, s1_d;
   logic               s2_valid_q, s2_valid_d;
   logic [EXP_W-1:0]   mux_out_q, mux_out_d;
   logic [MANT_W-1:0]  mant_big_q, mant_big_d;
   logic [MANT_W-1:0]  mant_small_q, mant_small_d;
   logic               sign_big_q, sign_big_d;
   logic               eff_sub_q, eff_sub_d;
   special_e           special_q, special_d;

   logic               accept;
   logic               s2_load;
   logic               a_is_big;
   logic [EXP_W-1:0]   exp_a, exp_b, exp_big, exp_small, exp_diff;
   logic               nan_any, inf_any;
   s1_t                s1_new;
   logic [MANT_W-1:0]  shifted_small;

   sticky_rshift u_sticky_rshift (
      .din  (s1_q.mant_small),
      .amt  (s1_q.shamt),
      .dout (shifted_small)
   );

   // S1: unpack, magnitude compare (tie keeps a), swap, exponent difference.
   always_comb begin
      a_is_big  = (a[30:0] >= b[30:0]);
      exp_a     = eff_exp(a[30:23]);
      exp_b     = eff_exp(b[30:23]);
      exp_big   = a_is_big ? exp_a : exp_b;
      exp_small = a_is_big ? exp_b : exp_a;
      exp_diff  = exp_big - exp_small;

      nan_any = ((a[30:23] == 8'hFF) && (a[22:0] != '0)) ||
                ((b[30:23] == 8'hFF) && (b[22:0] != '0));
      inf_any = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);

      s1_new.exp_big    = exp_big;
      s1_new.mant_big   = a_is_big ? unpack_mant(a[30:23], a[22:0])
                                   : unpack_mant(b[30:23], b[22:0]);
      s1_new.mant_small = a_is_big ? unpack_mant(b[30:23], b[22:0])
                                   : unpack_mant(a[30:23], a[22:0]);
      s1_new.shamt      = (exp_diff > EXP_W'(SHIFT_SAT)) ? SHAMT_W'(SHIFT_SAT)
                                                         : exp_diff[SHAMT_W-1:0];
      s1_new.sign_big   = a_is_big ? a[31] : b[31];
      s1_new.eff_sub    = a[31] ^ b[31];
      s1_new.special    = nan_any ? SPC_NAN : (inf_any ? SPC_INF : SPC_NORMAL);
   end

   // Handshake and pipeline advance; a stalled S2 freezes every output.
   always_comb begin
      in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
      accept   = in_valid && in_ready;
      s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_d       = s1_new;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d   = s2_valid_q;
      mux_out_d    = mux_out_q;
      mant_big_d   = mant_big_q;
      mant_small_d = mant_small_q;
      sign_big_d   = sign_big_q;
      eff_sub_d    = eff_sub_q;
      special_d    = special_q;
      if (s2_load) begin
         s2_valid_d   = 1'b1;
         mux_out_d    = s1_q.exp_big;
         mant_big_d   = s1_q.mant_big;
         mant_small_d = shifted_small;
         sign_big_d   = s1_q.sign_big;
         eff_sub_d    = s1_q.eff_sub;
         special_d    = s1_q.special;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_q         <= '0;
         s2_valid_q   <= 1'b0;
         mux_out_q    <= '0;
         mant_big_q   <= '0;
         mant_small_q <= '0;
         sign_big_q   <= 1'b0;
         eff_sub_q    <= 1'b0;
         special_q    <= SPC_NORMAL;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_q         <= s1_d;
         s2_valid_q   <= s2_valid_d;
         mux_out_q    <= mux_out_d;
         mant_big_q   <= mant_big_d;
         mant_small_q <= mant_small_d;
         sign_big_q   <= sign_big_d;
         eff_sub_q    <= eff_sub_d;
         special_q    <= special_d;
      end
   end

   always_comb begin
      out_valid  = s2_valid_q;
      mux_out    = mux_out_q;
      mant_big   = mant_big_q;
      mant_small = mant_small_q;
      sign_big   = sign_big_q;
      eff_sub    = eff_sub_q;
      special    = special_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_align_stage.sv
//------------------------------------------------------------------------------
// tb_align_stage : directed self-checking bench for align_stage
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_align_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  mux_out;
   logic [26:0] mant_big;
   logic [26:0] mant_small;
   logic        sign_big;
   logic        eff_sub;
   logic [1:0]  special;

   int n_cmp = 0;
   int n_err = 0;

   align_stage dut (
      .clk        (clk),
      .rst        (rst),
      .a          (a),
      .b          (b),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .mux_out    (mux_out),
      .mant_big   (mant_big),
      .mant_small (mant_small),
      .sign_big   (sign_big),
      .eff_sub    (eff_sub),
      .special    (special)
   );

   always #5 clk = ~clk;

   localparam int NV = 9;
   // Hand-computed vectors: a, b, mux_out, mant_big, mant_small, sign_big, eff_sub, special.
   logic [31:0] va [NV] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                            32'h3F800000, 32'h7F800000, 32'h7FC00000, 32'h3F800000,
                            32'h3F800000};
   logic [31:0] vb [NV] = '{32'h3F800000, 32'h3F000000, 32'h33800000, 32'h30800000,
                            32'hC0000000, 32'h3F800000, 32'hFF800000, 32'hBF800000,
                            32'h3D800001};
   logic [7:0]  em [NV] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h7F};
   logic [26:0] eb [NV] = '{27'h4000000, 27'h4000000, 27'h4000000, 27'h4000000,
                            27'h4000000, 27'h0, 27'h0, 27'h4000000, 27'h4000000};
   logic [26:0] es [NV] = '{27'h4000000, 27'h2000000, 27'h0000004, 27'h0000001,
                            27'h2000000, 27'h0, 27'h0, 27'h4000000, 27'h0400001};
   logic        esg[NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic        esb[NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [1:0]  esp[NV] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input int i);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".mux_out"},   32'(mux_out),   32'(em[i]));
      chk({tag, ".sign_big"},  32'(sign_big),  32'(esg[i]));
      chk({tag, ".eff_sub"},   32'(eff_sub),   32'(esb[i]));
      chk({tag, ".special"},   32'(special),   32'(esp[i]));
      if (esp[i] == 2'b00) begin
         chk({tag, ".mant_big"},   32'(mant_big),   32'(eb[i]));
         chk({tag, ".mant_small"}, 32'(mant_small), 32'(es[i]));
      end
   endtask

   task automatic drive(input int i);
      a        = va[i];
      b        = vb[i];
      in_valid = 1'b1;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, ".out_valid"},  32'(out_valid),  32'd0);
      chk({tag, ".mux_out"},    32'(mux_out),    32'd0);
      chk({tag, ".mant_big"},   32'(mant_big),   32'd0);
      chk({tag, ".mant_small"}, 32'(mant_small), 32'd0);
      chk({tag, ".sign_big"},   32'(sign_big),   32'd0);
      chk({tag, ".eff_sub"},    32'(eff_sub),    32'd0);
      chk({tag, ".special"},    32'(special),    32'd0);
   endtask

   initial begin
      int  acc;
      int  idx;
      int  sv [3];
      logic fire;

      rst = 1'b1; a = '0; b = '0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      step();
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk_zero_outputs("rst");

      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst.in_ready", 32'(in_ready), 32'd1);
      step();
      chk("post_rst.out_valid", 32'(out_valid), 32'd0);

      // Streaming, one vector per cycle: result i appears two edges after being driven.
      for (int i = 0; i < NV + 2; i++) begin
         if (i < NV) drive(i);
         else in_valid = 1'b0;
         if (i < NV) chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
         step();
         if (i == 0) chk("latency.out_valid", 32'(out_valid), 32'd0);
         else if (i - 1 < NV) chk_vec($sformatf("vec%0d", i - 1), i - 1);
         else chk("drain.out_valid", 32'(out_valid), 32'd0);
      end

      // Backpressure: 4 stalled cycles, 3 distinct inputs offered.
      sv = '{0, 1, 4};
      out_ready = 1'b0;
      acc = 0;
      idx = 0;
      drive(sv[0]);
      for (int k = 0; k < 4; k++) begin
         fire = in_valid && in_ready;
         step();
         if (fire) begin
            acc++;
            idx++;
            if (idx < 3) drive(sv[idx]);
         end
      end
      chk("stall.accepted", 32'(acc), 32'd2);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      chk_vec("stall.hold", sv[0]);

      out_ready = 1'b1;
      #1;
      chk("unstall.in_ready", 32'(in_ready), 32'd1);
      for (int k = 1; k < 4; k++) begin
         fire = in_valid && in_ready;
         step();
         if (fire) begin
            idx++;
            if (idx < 3) drive(sv[idx]);
            else in_valid = 1'b0;
         end
         if (k < 3) chk_vec($sformatf("unstall%0d", k), sv[k]);
         else chk("unstall.end.out_valid", 32'(out_valid), 32'd0);
      end
      chk("unstall.total_accepted", 32'(idx), 32'd3);

      // Reset with both stages occupied discards everything.
      out_ready = 1'b0;
      drive(2);
      step();
      drive(4);
      step();
      chk("full.out_valid", 32'(out_valid), 32'd1);
      chk("full.in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      step();
      chk_zero_outputs("rst_full");
      chk("rst_full.in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_full.rel.in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("rst_full.flush%0d.out_valid", k), 32'(out_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
